// File: rtl/pulse_filter_pkg.sv
// pulse_filter_pkg
// Shared constants, FSM state type and helpers for the pulse filter and its
// configuration sequencer. Keeping widths here lets the filter top and the
// controller agree on channel count and coefficient width.
package pulse_filter_pkg;

  localparam int CH_NUM    = 32;
  localparam int COEFF_W   = 16;
  localparam int QUIET_CYC = 4;
  localparam int WAIT_MAX  = 20000;

  localparam logic [COEFF_W-1:0] MIN_COEFF = 16'd1;
  localparam logic [COEFF_W-1:0] RST_COEFF = 16'd20;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_QUIET = 2'd1,
    APPLY      = 2'd2,
    SETTLE     = 2'd3
  } cfg_state_e;

  // A zero-length filter window is meaningless; substitute the minimum.
  function automatic logic [COEFF_W-1:0] clamp_coeff(
    input logic [COEFF_W-1:0] coeff,
    input logic [COEFF_W-1:0] min_coeff
  );
    return (coeff == '0) ? min_coeff : coeff;
  endfunction

endpackage

// File: rtl/pulse_quiet_det.sv
// pulse_quiet_det
// Counts consecutive cycles in which every channel's raw input matches its
// filtered output (no channel inside a filter window).
// Ports:
//   clk_20m, rst_n     clock, asynchronous active-low reset
//   clear              hold the run counter at zero
//   pulse_raw          raw pulse inputs
//   pulse_filtered     filter outputs
//   quiet_ok           this cycle is quiet and completes a run of QUIET_CYC
module pulse_quiet_det
  import pulse_filter_pkg::*;
#(
  parameter int Q_CH_NUM    = CH_NUM,
  parameter int Q_QUIET_CYC = QUIET_CYC
) (
  input  logic                clk_20m,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [Q_CH_NUM-1:0] pulse_raw,
  input  logic [Q_CH_NUM-1:0] pulse_filtered,
  output logic                quiet_ok
);

  localparam int CNT_W = $clog2(Q_QUIET_CYC + 1);

  logic [CNT_W-1:0] quiet_cnt;
  logic             q;

  assign q        = ~|(pulse_raw ^ pulse_filtered);
  // Qualified combinationally with q so the run completes on its last
  // quiet cycle rather than one cycle later.
  assign quiet_ok = q && (quiet_cnt == CNT_W'(Q_QUIET_CYC - 1));

  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) begin
      quiet_cnt <= '0;
    end else if (clear || !q) begin
      quiet_cnt <= '0;
    end else if (!quiet_ok) begin
      quiet_cnt <= quiet_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_filter_cfg_ctrl.sv
// pulse_filter_cfg_ctrl
// Configuration sequencer for the pulse filter. Accepts a coefficient request,
// holds it in a shadow register, applies it to filter_coeff only when all
// channels are quiet (or after a timeout), then waits one full filter window
// before reporting completion.
// Handshake: a request transfers on any rising clk_20m edge where
//   cfg_valid & cfg_ready; cfg_ready is high only in IDLE. cfg_valid seen
//   while cfg_ready is low is ignored (no queueing) and is not remembered.
// Ports:
//   clk_20m, rst_n   20 MHz clock, asynchronous active-low reset
//   cfg_valid        request valid
//   cfg_coeff        requested coefficient
//   cfg_ready        controller idle, request can transfer
//   pulse_raw        raw pulse inputs
//   pulse_filtered   filter outputs
//   filter_coeff     coefficient driven to the filter
//   busy             request in progress
//   apply_done       one-cycle pulse: new coefficient applied and settled
//   apply_forced     with apply_done when the apply was timeout-forced
module pulse_filter_cfg_ctrl
  import pulse_filter_pkg::*;
(
  input  logic               clk_20m,
  input  logic               rst_n,
  input  logic               cfg_valid,
  input  logic [COEFF_W-1:0] cfg_coeff,
  output logic               cfg_ready,
  input  logic [CH_NUM-1:0]  pulse_raw,
  input  logic [CH_NUM-1:0]  pulse_filtered,
  output logic [COEFF_W-1:0] filter_coeff,
  output logic               busy,
  output logic               apply_done,
  output logic               apply_forced
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam int SET_W  = COEFF_W + 1;

  cfg_state_e         state, state_nxt;
  logic [COEFF_W-1:0] shadow;
  logic [COEFF_W-1:0] clamped;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic               forced;
  logic               quiet_ok;

  logic accept;       // handshake fired this cycle
  logic same_coeff;   // accepted value already in effect
  logic force_go;     // leaving WAIT_QUIET on timeout
  logic settle_end;   // last SETTLE cycle

  assign clamped = clamp_coeff(cfg_coeff, MIN_COEFF);

  pulse_quiet_det #(
    .Q_CH_NUM    (CH_NUM),
    .Q_QUIET_CYC (QUIET_CYC)
  ) u_quiet_det (
    .clk_20m        (clk_20m),
    .rst_n          (rst_n),
    .clear          (state != WAIT_QUIET),
    .pulse_raw      (pulse_raw),
    .pulse_filtered (pulse_filtered),
    .quiet_ok       (quiet_ok)
  );

  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    same_coeff = 1'b0;
    force_go   = 1'b0;
    settle_end = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          accept = 1'b1;
          if (clamped == filter_coeff) same_coeff = 1'b1;
          else                         state_nxt  = WAIT_QUIET;
        end
      end
      WAIT_QUIET: begin
        // Quiet takes priority when it coincides with the timeout.
        if (quiet_ok) begin
          state_nxt = APPLY;
        end else if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
          state_nxt = APPLY;
          force_go  = 1'b1;
        end
      end
      APPLY: state_nxt = SETTLE;
      SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt  = IDLE;
          settle_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      wait_cnt     <= '0;
      settle_cnt   <= '0;
      forced       <= 1'b0;
      filter_coeff <= RST_COEFF;
      cfg_ready    <= 1'b1;
      busy         <= 1'b0;
      apply_done   <= 1'b0;
      apply_forced <= 1'b0;
    end else begin
      if (accept && !same_coeff) shadow <= clamped;

      if (state == WAIT_QUIET) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                     wait_cnt <= '0;

      if (state == WAIT_QUIET && state_nxt == APPLY) forced <= force_go;

      if (state == APPLY) begin
        filter_coeff <= shadow;
        // One extra bit so a 0xFFFF window still counts 65536 cycles.
        settle_cnt   <= {1'b0, shadow};
      end else if (state == SETTLE && settle_cnt != '0) begin
        settle_cnt   <= settle_cnt - SET_W'(1);
      end

      // Registered from the next state so they line up with the FSM.
      cfg_ready    <= (state_nxt == IDLE);
      busy         <= (state_nxt != IDLE);
      apply_done   <= settle_end | (accept & same_coeff);
      apply_forced <= settle_end & forced;
    end
  end

endmodule

// File: doc/pulse_filter_cfg_ctrl.md
Name: pulse_filter_cfg_ctrl

Overview:
- Configuration sequencer for the 32-channel pulse filter.
- Accepts coefficient change requests over a valid/ready handshake and holds each in a shadow register.
- Applies the new value to the filter's `filter_coeff` input only at a safe point: all channels quiet, or a timeout expires.
- After applying, waits out one full filter window before reporting completion, so software never sees a half-filtered transient.

Parameters:
- CH_NUM, 32, number of pulse channels observed.
- COEFF_W, 16, width of the filter coefficient (unit: 1 clk_20m cycle).
- QUIET_CYC, 4, consecutive quiet cycles required before apply (must be >= 1).
- WAIT_MAX, 20000, max cycles to wait for quiet before a forced apply (1 ms at 20 MHz).
- MIN_COEFF, 1, substitute value when a request carries coefficient 0.
- RST_COEFF, 20, coefficient driven out of reset.

Ports:
- clk_20m  in  1  20 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  request valid.
- cfg_coeff  in  COEFF_W  requested filter coefficient.
- cfg_ready  out  1  controller can accept a request.
- pulse_raw  in  CH_NUM  raw pulse inputs (same bus the filter sees).
- pulse_filtered  in  CH_NUM  filter outputs.
- filter_coeff  out  COEFF_W  coefficient driven to the filter.
- busy  out  1  request in progress.
- apply_done  out  1  one-cycle pulse: new coefficient applied and settled.
- apply_forced  out  1  one-cycle pulse coincident with apply_done when the apply was timeout-forced.

Behaviour:
- Clock and reset: single clock `clk_20m`; reset `rst_n` is asynchronous, active-low.
- Reset values: filter_coeff=RST_COEFF, cfg_ready=1, busy=0, apply_done=0, apply_forced=0, FSM=IDLE, all counters 0. Assertion mid-operation aborts immediately; the shadow value is lost.
- All outputs are registered. busy = (state != IDLE). cfg_ready = (state == IDLE).
- Channel quiet condition: q = ~|(pulse_raw ^ pulse_filtered). Quiet means no channel is inside a filter window.
- FSM states: IDLE, WAIT_QUIET, APPLY, SETTLE.
- IDLE:
  - Handshake fires on a cycle with cfg_valid & cfg_ready.
  - shadow <= (cfg_coeff==0 ? MIN_COEFF : cfg_coeff).
  - quiet_cnt <= 0, wait_cnt <= 0, next state WAIT_QUIET.
  - If the clamped value equals filter_coeff, go directly to IDLE instead, with apply_done pulsed the next cycle. No settle, apply_forced=0.
- WAIT_QUIET:
  - quiet_cnt increments when q and clears when !q.
  - wait_cnt increments every cycle.
  - If q and quiet_cnt==QUIET_CYC-1: go to APPLY, forced=0.
  - Else if wait_cnt==WAIT_MAX-1: go to APPLY, forced=1.
  - If both occur in the same cycle, quiet wins (forced=0).
- APPLY (1 cycle):
  - filter_coeff <= shadow.
  - settle_cnt <= shadow (COEFF_W+1 bits, no overflow at 0xFFFF).
  - Next state SETTLE.
- SETTLE:
  - settle_cnt decrements by 1 per cycle.
  - At settle_cnt==0: go to IDLE; apply_done=1 for one cycle; apply_forced=forced for the same cycle.
- Latency:
  - Handshake at cycle T with channels continuously quiet: filter_coeff changes at T+QUIET_CYC+2.
  - apply_done asserts exactly shadow+1 cycles after the filter_coeff change.
  - cfg_ready returns to 1 in the same cycle as apply_done.
- Requests while busy:
  - Not accepted. cfg_valid held while cfg_ready=0 is ignored until IDLE; there is no queue.
  - cfg_coeff changes while not ready have no effect.
- filter_coeff never changes except in APPLY or on reset.

Decomposition:
- Package pulse_filter_pkg:
  - Constants CH_NUM, COEFF_W, RST_COEFF.
  - FSM state enum (IDLE/WAIT_QUIET/APPLY/SETTLE).
  - Shared with the filter top so widths stay consistent.
- One sub-module, pulse_quiet_det:
  - Inputs: raw/filtered buses, clear.
  - Output: quiet_ok, asserted when QUIET_CYC consecutive quiet cycles are seen.
  - The FSM, shadow, and wait/settle counters stay in pulse_filter_cfg_ctrl.

Test Plan:
- Reset check: after reset release, filter_coeff=20, cfg_ready=1, busy=0; apply_done and apply_forced stay 0 for 100 cycles with no request.
- Quiet apply: pulse_raw==pulse_filtered==0; request coeff=50 at T -> filter_coeff=50 at T+6; apply_done at T+57; cfg_ready high again at T+57.
- Forced apply: hold pulse_raw[3]=1 with pulse_filtered[3]=0 forever; request coeff=8 -> forced apply after 20000 wait cycles; apply_done and apply_forced both pulse 9 cycles later.
- Quiet-count restart: request coeff=10 with channel 7 mismatched in cycles 2 and 5 of WAIT_QUIET -> apply only after 4 clean consecutive cycles following the last mismatch; apply_forced=0.
- Edge values:
  - Request coeff=0 -> filter_coeff=1.
  - Request equal to current (20) -> apply_done the next cycle, filter_coeff unchanged.
  - Request 0xFFFF -> apply_done exactly 65536 cycles after apply, no wrap.
- Busy/reset: a second request during SETTLE is not accepted (cfg_ready=0). Then rst_n low mid-SETTLE -> filter_coeff=20 asynchronously and no apply_done.
